// File: rtl/alu_operand_stage_if.sv
// Bundles the decode-side, forwarding and ALU-side signals of the operand stage.
// The master modport is the surrounding pipeline; the slave modport is the operand stage.
interface alu_operand_stage_if #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic                  id_ready;
  logic [1:0]            id_a_sel;
  logic [1:0]            id_b_sel;
  logic                  id_is_store;
  logic [REG_ADDR_W-1:0] id_rega_addr;
  logic [REG_ADDR_W-1:0] id_regb_addr;
  logic [DATA_W-1:0]     id_rega_data;
  logic [DATA_W-1:0]     id_regb_data;
  logic [DATA_W-1:0]     id_imm;
  logic [DATA_W-1:0]     id_pc;

  logic                  ex_wr_en;
  logic                  ex_is_load;
  logic [REG_ADDR_W-1:0] ex_wr_addr;
  logic [DATA_W-1:0]     ex_wr_data;

  logic                  mem_wr_en;
  logic [REG_ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0]     mem_wr_data;

  logic                  flush;

  logic                  ex_valid;
  logic                  ex_ready;
  logic [DATA_W-1:0]     ex_a;
  logic [DATA_W-1:0]     ex_b;
  logic [DATA_W-1:0]     ex_store_data;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output id_valid, id_a_sel, id_b_sel, id_is_store,
           id_rega_addr, id_regb_addr, id_rega_data, id_regb_data, id_imm, id_pc,
           ex_wr_en, ex_is_load, ex_wr_addr, ex_wr_data,
           mem_wr_en, mem_wr_addr, mem_wr_data, flush, ex_ready,
    input  id_ready, ex_valid, ex_a, ex_b, ex_store_data, stall_cnt
  );

  modport slave (
    input  id_valid, id_a_sel, id_b_sel, id_is_store,
           id_rega_addr, id_regb_addr, id_rega_data, id_regb_data, id_imm, id_pc,
           ex_wr_en, ex_is_load, ex_wr_addr, ex_wr_data,
           mem_wr_en, mem_wr_addr, mem_wr_data, flush, ex_ready,
    output id_ready, ex_valid, ex_a, ex_b, ex_store_data, stall_cnt
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: operand A/B selection with EX/MEM forwarding, load-use bubble
// insertion and a single valid/ready output slot feeding the ALU.
module alu_operand_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  alu_operand_stage_if.slave bus
);

  localparam logic [1:0] A_REGA = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;
  localparam logic [1:0] A_REGB = 2'd3;

  localparam logic [1:0] B_IMM  = 2'd0;
  localparam logic [1:0] B_REGB = 2'd1;
  localparam logic [1:0] B_ZERO = 2'd2;
  localparam logic [1:0] B_ONE  = 2'd3;

  localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] opa_nxt;
  logic [DATA_W-1:0] opb_nxt;

  logic              rega_used;
  logic              regb_used;
  logic              load_in_ex;
  logic              hazard;
  logic              slot_free;

  logic              ex_valid_q;
  logic [DATA_W-1:0] ex_a_q;
  logic [DATA_W-1:0] ex_b_q;
  logic [DATA_W-1:0] ex_store_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  // A load in EX has no data yet, so it is excluded from EX forwarding; the hazard
  // logic below holds the consumer back one cycle until MEM forwarding can serve it.
  always_comb begin
    fwd_a = bus.id_rega_data;
    if (bus.ex_wr_en && !bus.ex_is_load && (bus.ex_wr_addr == bus.id_rega_addr)) begin
      fwd_a = bus.ex_wr_data;
    end else if (bus.mem_wr_en && (bus.mem_wr_addr == bus.id_rega_addr)) begin
      fwd_a = bus.mem_wr_data;
    end
  end

  always_comb begin
    fwd_b = bus.id_regb_data;
    if (bus.ex_wr_en && !bus.ex_is_load && (bus.ex_wr_addr == bus.id_regb_addr)) begin
      fwd_b = bus.ex_wr_data;
    end else if (bus.mem_wr_en && (bus.mem_wr_addr == bus.id_regb_addr)) begin
      fwd_b = bus.mem_wr_data;
    end
  end

  always_comb begin
    opa_nxt = '0;
    unique case (bus.id_a_sel)
      A_REGA:  opa_nxt = fwd_a;
      A_PC:    opa_nxt = bus.id_pc;
      A_ZERO:  opa_nxt = '0;
      A_REGB:  opa_nxt = fwd_b;
      default: opa_nxt = '0;
    endcase
  end

  always_comb begin
    opb_nxt = '0;
    unique case (bus.id_b_sel)
      B_IMM:   opb_nxt = bus.id_imm;
      B_REGB:  opb_nxt = fwd_b;
      B_ZERO:  opb_nxt = '0;
      B_ONE:   opb_nxt = DATA_ONE;
      default: opb_nxt = '0;
    endcase
  end

  // A_REGB reads through the regb port, so it counts as a regb use for hazards.
  assign rega_used  = (bus.id_a_sel == A_REGA);
  assign regb_used  = (bus.id_b_sel == B_REGB) || (bus.id_a_sel == A_REGB) || bus.id_is_store;
  assign load_in_ex = bus.id_valid && bus.ex_wr_en && bus.ex_is_load;

  assign hazard = load_in_ex &&
                  ((rega_used && (bus.id_rega_addr == bus.ex_wr_addr)) ||
                   (regb_used && (bus.id_regb_addr == bus.ex_wr_addr)));

  assign slot_free = !ex_valid_q || bus.ex_ready;

  assign bus.id_ready = rst && slot_free && !hazard && !bus.flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q  <= 1'b0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_store_q  <= '0;
      stall_cnt_q <= '0;
    end else if (bus.flush) begin
      ex_valid_q <= 1'b0;
    end else if (slot_free) begin
      if (hazard) begin
        ex_valid_q <= 1'b0;
        if (stall_cnt_q != CNT_MAX) begin
          stall_cnt_q <= stall_cnt_q + CNT_ONE;
        end
      end else if (bus.id_valid) begin
        ex_valid_q <= 1'b1;
        ex_a_q     <= opa_nxt;
        ex_b_q     <= opb_nxt;
        ex_store_q <= fwd_b;
      end else begin
        ex_valid_q <= 1'b0;
      end
    end
  end

  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_a          = ex_a_q;
  assign bus.ex_b          = ex_b_q;
  assign bus.ex_store_data = ex_store_q;
  assign bus.stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: select-matrix table, directed hazard,
// back-pressure and saturation sequences, then randomized traffic against a reference model.
module tb_alu_operand_stage;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int CW = 4;

  logic clk;
  logic rst;

  alu_operand_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) bus ();

  alu_operand_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic          m_valid;
  logic [DW-1:0] m_a, m_b, m_sd;
  logic [CW-1:0] m_cnt;
  logic          last_ready;

  typedef struct {
    logic [1:0]    a_sel;
    logic [1:0]    b_sel;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
  } sel_vec_t;

  sel_vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_a     = '0;
    m_b     = '0;
    m_sd    = '0;
    m_cnt   = '0;
  endtask

  task automatic set_idle();
    bus.id_valid     = 1'b0;
    bus.id_a_sel     = 2'd0;
    bus.id_b_sel     = 2'd0;
    bus.id_is_store  = 1'b0;
    bus.id_rega_addr = '0;
    bus.id_regb_addr = '0;
    bus.id_rega_data = '0;
    bus.id_regb_data = '0;
    bus.id_imm       = '0;
    bus.id_pc        = '0;
    bus.ex_wr_en     = 1'b0;
    bus.ex_is_load   = 1'b0;
    bus.ex_wr_addr   = '0;
    bus.ex_wr_data   = '0;
    bus.mem_wr_en    = 1'b0;
    bus.mem_wr_addr  = '0;
    bus.mem_wr_data  = '0;
    bus.flush        = 1'b0;
    bus.ex_ready     = 1'b1;
  endtask

  // Reference value a source register would deliver: newest in-flight producer wins,
  // a load still in EX cannot deliver.
  function automatic logic [DW-1:0] ref_reg(input logic [AW-1:0] addr, input logic [DW-1:0] rf,
                                            input logic exw, input logic exl, input logic [AW-1:0] exa,
                                            input logic [DW-1:0] exd, input logic mw,
                                            input logic [AW-1:0] ma, input logic [DW-1:0] md);
    logic [DW-1:0] v;
    v = rf;
    if (mw && ma == addr) v = md;
    if (exw && !exl && exa == addr) v = exd;
    return v;
  endfunction

  // One clock: sample id_ready before the edge, predict the slot, compare after the edge.
  task automatic step();
    logic [DW-1:0] fa, fb, na, nb;
    logic [DW-1:0] a_src[4];
    logic [DW-1:0] b_src[4];
    logic [AW-1:0] reads[$];
    logic          haz, free, exp_ready;
    #2;
    fa = ref_reg(bus.id_rega_addr, bus.id_rega_data, bus.ex_wr_en, bus.ex_is_load, bus.ex_wr_addr,
                 bus.ex_wr_data, bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data);
    fb = ref_reg(bus.id_regb_addr, bus.id_regb_data, bus.ex_wr_en, bus.ex_is_load, bus.ex_wr_addr,
                 bus.ex_wr_data, bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data);
    a_src = '{fa, bus.id_pc, 16'h0000, fb};
    b_src = '{bus.id_imm, fb, 16'h0000, 16'h0001};
    na = a_src[bus.id_a_sel];
    nb = b_src[bus.id_b_sel];
    reads.delete();
    if (bus.id_a_sel == 2'd0) reads.push_back(bus.id_rega_addr);
    if (bus.id_a_sel == 2'd3 || bus.id_b_sel == 2'd1 || bus.id_is_store) reads.push_back(bus.id_regb_addr);
    haz = 1'b0;
    if (bus.id_valid && bus.ex_wr_en && bus.ex_is_load)
      foreach (reads[i]) if (reads[i] == bus.ex_wr_addr) haz = 1'b1;
    free      = !m_valid || bus.ex_ready;
    exp_ready = rst && free && !haz && !bus.flush;
    last_ready = bus.id_ready;
    chk("id_ready", 32'(bus.id_ready), 32'(exp_ready));
    @(posedge clk);
    #1;
    if (bus.flush) m_valid = 1'b0;
    else if (free && haz) begin
      m_valid = 1'b0;
      if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
    end else if (free && bus.id_valid) begin
      m_valid = 1'b1;
      m_a = na;
      m_b = nb;
      m_sd = fb;
    end else if (free) m_valid = 1'b0;
    chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
    chk("ex_a", 32'(bus.ex_a), 32'(m_a));
    chk("ex_b", 32'(bus.ex_b), 32'(m_b));
    chk("ex_store_data", 32'(bus.ex_store_data), 32'(m_sd));
    chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
  endtask

  // Asynchronous reset pulse away from any clock edge; outputs must clear immediately.
  task automatic async_reset(input string tag);
    #3;
    rst = 1'b0;
    #1;
    chk({tag, "_valid"}, 32'(bus.ex_valid), 32'd0);
    chk({tag, "_a"}, 32'(bus.ex_a), 32'd0);
    chk({tag, "_b"}, 32'(bus.ex_b), 32'd0);
    chk({tag, "_sd"}, 32'(bus.ex_store_data), 32'd0);
    chk({tag, "_cnt"}, 32'(bus.stall_cnt), 32'd0);
    chk({tag, "_ready"}, 32'(bus.id_ready), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic set_load_hazard(input logic [AW-1:0] addr);
    bus.ex_wr_en   = 1'b1;
    bus.ex_is_load = 1'b1;
    bus.ex_wr_addr = addr;
  endtask

  initial begin
    vecs[0] = '{2'd0, 2'd0, 16'h00AA, 16'h1234};
    vecs[1] = '{2'd1, 2'd0, 16'h0040, 16'h1234};
    vecs[2] = '{2'd2, 2'd0, 16'h0000, 16'h1234};
    vecs[3] = '{2'd3, 2'd0, 16'h00BB, 16'h1234};
    vecs[4] = '{2'd0, 2'd1, 16'h00AA, 16'h00BB};
    vecs[5] = '{2'd0, 2'd2, 16'h00AA, 16'h0000};
    vecs[6] = '{2'd0, 2'd3, 16'h00AA, 16'h0001};
    vecs[7] = '{2'd1, 2'd1, 16'h0040, 16'h00BB};

    rst = 1'b1;
    set_idle();
    model_reset();
    #1 rst = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_a", 32'(bus.ex_a), 32'd0);
    chk("rst_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("rst_ready", 32'(bus.id_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // select matrix
    bus.id_rega_addr = 3'd1;
    bus.id_regb_addr = 3'd2;
    bus.id_rega_data = 16'h00AA;
    bus.id_regb_data = 16'h00BB;
    bus.id_imm       = 16'h1234;
    bus.id_pc        = 16'h0040;
    bus.id_valid     = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.id_a_sel = vecs[i].a_sel;
      bus.id_b_sel = vecs[i].b_sel;
      step();
      chk($sformatf("sel_a[%0d]", i), 32'(bus.ex_a), 32'(vecs[i].exp_a));
      chk($sformatf("sel_b[%0d]", i), 32'(bus.ex_b), 32'(vecs[i].exp_b));
      chk($sformatf("sel_sd[%0d]", i), 32'(bus.ex_store_data), 32'h00BB);
    end

    chk("pre_reset_valid", 32'(bus.ex_valid), 32'd1);
    async_reset("midrst");

    // forwarding priority on operand A
    bus.id_valid     = 1'b1;
    bus.id_a_sel     = 2'd0;
    bus.id_b_sel     = 2'd0;
    bus.id_rega_addr = 3'd3;
    bus.id_rega_data = 16'h0333;
    bus.ex_wr_en     = 1'b1;
    bus.ex_wr_addr   = 3'd3;
    bus.ex_wr_data   = 16'h1111;
    bus.mem_wr_en    = 1'b1;
    bus.mem_wr_addr  = 3'd3;
    bus.mem_wr_data  = 16'h2222;
    step();
    chk("fwd_ex", 32'(bus.ex_a), 32'h1111);
    bus.ex_wr_en = 1'b0;
    step();
    chk("fwd_mem", 32'(bus.ex_a), 32'h2222);
    bus.mem_wr_en = 1'b0;
    step();
    chk("fwd_rf", 32'(bus.ex_a), 32'h0333);

    // load-use on regb operand
    bus.id_a_sel     = 2'd1;
    bus.id_b_sel     = 2'd1;
    bus.id_regb_addr = 3'd2;
    bus.id_regb_data = 16'h0F0F;
    set_load_hazard(3'd2);
    step();
    chk("lu_ready", 32'(last_ready), 32'd0);
    chk("lu_bubble", 32'(bus.ex_valid), 32'd0);
    chk("lu_cnt", 32'(bus.stall_cnt), 32'd1);
    bus.ex_wr_en    = 1'b0;
    bus.ex_is_load  = 1'b0;
    bus.mem_wr_en   = 1'b1;
    bus.mem_wr_addr = 3'd2;
    bus.mem_wr_data = 16'h5A5A;
    step();
    chk("lu_mem_valid", 32'(bus.ex_valid), 32'd1);
    chk("lu_mem_b", 32'(bus.ex_b), 32'h5A5A);
    chk("lu_mem_sd", 32'(bus.ex_store_data), 32'h5A5A);

    // store-data-only dependency stalls; the same instruction without the store does not
    bus.mem_wr_en   = 1'b0;
    bus.id_b_sel    = 2'd0;
    bus.id_is_store = 1'b1;
    set_load_hazard(3'd2);
    step();
    chk("st_ready", 32'(last_ready), 32'd0);
    chk("st_bubble", 32'(bus.ex_valid), 32'd0);
    chk("st_cnt", 32'(bus.stall_cnt), 32'd2);
    bus.id_is_store = 1'b0;
    step();
    chk("nost_valid", 32'(bus.ex_valid), 32'd1);
    chk("nost_cnt", 32'(bus.stall_cnt), 32'd2);

    // flush beats a pending hazard and is not counted
    bus.id_is_store = 1'b1;
    bus.flush       = 1'b1;
    step();
    chk("flush_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush_cnt", 32'(bus.stall_cnt), 32'd2);
    bus.flush       = 1'b0;
    bus.id_is_store = 1'b0;
    bus.ex_wr_en    = 1'b0;
    bus.ex_is_load  = 1'b0;

    // back-pressure with a hazard showing upstream
    bus.id_a_sel = 2'd1;
    bus.id_b_sel = 2'd0;
    bus.id_pc    = 16'h0100;
    bus.id_imm   = 16'h0777;
    step();
    bus.ex_ready     = 1'b0;
    bus.id_a_sel     = 2'd0;
    bus.id_rega_addr = 3'd5;
    bus.id_pc        = 16'h0200;
    bus.id_imm       = 16'h0888;
    set_load_hazard(3'd5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("bp_ready[%0d]", i), 32'(last_ready), 32'd0);
      chk($sformatf("bp_valid[%0d]", i), 32'(bus.ex_valid), 32'd1);
      chk($sformatf("bp_a[%0d]", i), 32'(bus.ex_a), 32'h0100);
      chk($sformatf("bp_b[%0d]", i), 32'(bus.ex_b), 32'h0777);
      chk($sformatf("bp_cnt[%0d]", i), 32'(bus.stall_cnt), 32'd2);
    end
    bus.ex_wr_en   = 1'b0;
    bus.ex_is_load = 1'b0;
    bus.id_a_sel   = 2'd1;
    bus.ex_ready   = 1'b1;
    step();
    chk("bp_rel_ready", 32'(last_ready), 32'd1);
    chk("bp_rel_a", 32'(bus.ex_a), 32'h0200);
    chk("bp_rel_b", 32'(bus.ex_b), 32'h0888);

    // stall counter saturation, flush at saturation, no wrap
    bus.id_a_sel     = 2'd0;
    bus.id_rega_addr = 3'd6;
    set_load_hazard(3'd6);
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt", 32'(bus.stall_cnt), 32'hF);
    bus.flush = 1'b1;
    step();
    chk("sat_flush_valid", 32'(bus.ex_valid), 32'd0);
    chk("sat_flush_cnt", 32'(bus.stall_cnt), 32'hF);
    bus.flush = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("sat_nowrap", 32'(bus.stall_cnt), 32'hF);

    // randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      if (i % 300 == 299) async_reset("rnd_rst");
      bus.id_valid     = ($urandom_range(0, 9) < 8);
      bus.id_a_sel     = 2'($urandom_range(0, 3));
      bus.id_b_sel     = 2'($urandom_range(0, 3));
      bus.id_is_store  = ($urandom_range(0, 3) == 0);
      bus.id_rega_addr = 3'($urandom_range(0, 7));
      bus.id_regb_addr = 3'($urandom_range(0, 7));
      bus.id_rega_data = 16'($urandom);
      bus.id_regb_data = 16'($urandom);
      bus.id_imm       = 16'($urandom);
      bus.id_pc        = 16'($urandom);
      bus.ex_wr_en     = ($urandom_range(0, 1) == 1);
      bus.ex_is_load   = ($urandom_range(0, 4) < 2);
      bus.ex_wr_addr   = 3'($urandom_range(0, 7));
      bus.ex_wr_data   = 16'($urandom);
      bus.mem_wr_en    = ($urandom_range(0, 1) == 1);
      bus.mem_wr_addr  = 3'($urandom_range(0, 7));
      bus.mem_wr_data  = 16'($urandom);
      bus.flush        = ($urandom_range(0, 15) == 0);
      bus.ex_ready     = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
